// File: rtl/mips_pkg.sv
// Shared types and constants for the EX-stage ALU control and multiply/divide unit.
package mips_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_NOR  = 4'b0100,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SLL  = 4'b1001,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011
  } alu_op_e;

  // R-type funct codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // Instruction class from the main decoder
  localparam logic [1:0] CTRL_MEM  = 2'b00;
  localparam logic [1:0] CTRL_BR   = 2'b01;
  localparam logic [1:0] CTRL_R    = 2'b10;
  localparam logic [1:0] CTRL_SLTI = 2'b11;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Iterative multiply/divide datapath: one product or quotient bit per run cycle.
// Operands are unsigned magnitudes; sign correction happens in the controller.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] shreg,
  output logic             last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // Multiply shifts {acc,sh} right after a conditional add; divide shifts left and trial-subtracts.
  always_comb begin
    acc_d  = acc_q;
    sh_d   = sh_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    sum    = {1'b0, acc_q} + {1'b0, (sh_q[0] ? b_q : '0)};
    rem_sh = {acc_q, sh_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_q};
    if (load) begin
      acc_d = '0;
      sh_d  = a_in;
      b_d   = b_in;
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
      if (is_div) begin
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc_d, sh_d} = {sum, sh_q[WIDTH-1:1]};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      sh_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc   = acc_q;
  assign shreg = sh_q;
  assign last  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_md_ctrl.sv
// EX-stage ALU control: funct decode plus a sequential mult/div unit owning HI/LO.
// Handshake: md_stall high means EX (and earlier stages) must hold its instruction
// and keep instr_valid asserted; the FSM only samples new requests in IDLE.
module alu_md_ctrl import mips_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       funct,
  input  logic [1:0]       alu_ctrl,
  input  logic             instr_valid,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [OP_W-1:0]  alu_op,
  output logic             illegal,
  output logic             md_stall,
  output logic [WIDTH-1:0] md_result,
  output logic             md_done,
  output logic             div_by_zero,
  output md_state_e        dbg_state
);

  md_state_e          state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               div_q, div_d;

  alu_op_e            op;
  logic               is_r, md_op, mf_op, mt_op, signed_op, div_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   core_acc, core_sh;
  logic               core_load, core_run, core_last;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               stall_raw, done_raw, read_ok;

  assign is_r      = (alu_ctrl == CTRL_R);
  assign md_op     = instr_valid && is_r && (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign mf_op     = instr_valid && is_r && (funct inside {F_MFHI, F_MFLO});
  assign mt_op     = instr_valid && is_r && (funct inside {F_MTHI, F_MTLO});
  assign signed_op = (funct == F_MULT) || (funct == F_DIV);
  assign div_op    = (funct == F_DIV) || (funct == F_DIVU);
  assign a_mag     = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign b_mag     = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  assign prod      = {core_acc, core_sh};
  assign prod_fix  = neg_q ? -prod : prod;

  // ALU operation decode; HI/LO and mult/div functs are legal and default to ADD
  always_comb begin
    op      = ALU_ADD;
    illegal = 1'b0;
    case (alu_ctrl)
      CTRL_MEM:  op = ALU_ADD;
      CTRL_BR:   op = ALU_SUB;
      CTRL_SLTI: op = ALU_SLT;
      default: begin
        case (funct)
          F_ADD, F_ADDU: op = ALU_ADD;
          F_SUB, F_SUBU: op = ALU_SUB;
          F_AND:         op = ALU_AND;
          F_OR:          op = ALU_OR;
          F_XOR:         op = ALU_XOR;
          F_NOR:         op = ALU_NOR;
          F_SLT:         op = ALU_SLT;
          F_SLTU:        op = ALU_SLTU;
          F_SLL:         op = ALU_SLL;
          F_SRL:         op = ALU_SRL;
          F_SRA:         op = ALU_SRA;
          F_MFHI, F_MTHI, F_MFLO, F_MTLO,
          F_MULT, F_MULTU, F_DIV, F_DIVU: op = ALU_ADD;
          default: begin
            op      = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
    alu_op = OP_W'(op);
  end

  // Mult/div sequencing, sign fix-up and HI/LO updates
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    div_d     = div_q;
    core_load = 1'b0;
    core_run  = 1'b0;
    stall_raw = 1'b0;
    done_raw  = 1'b0;
    read_ok   = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        read_ok = 1'b1;
        if (md_op) begin
          stall_raw = 1'b1;
          dbz_d     = 1'b0;
          div_d     = div_op;
          neg_d     = signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          rneg_d    = signed_op && rs_val[WIDTH-1];
          if (div_op && (rt_val == '0)) begin
            lo_d    = '1;
            hi_d    = rs_val;
            dbz_d   = 1'b1;
            state_d = MD_DONE;
          end else begin
            core_load = 1'b1;
            state_d   = div_op ? MD_DIV : MD_MUL;
          end
        end else if (mt_op) begin
          if (funct == F_MTHI) hi_d = rs_val;
          else                 lo_d = rs_val;
          dbz_d = 1'b0;
        end
      end
      MD_MUL, MD_DIV: begin
        stall_raw = 1'b1;
        core_run  = 1'b1;
        if (core_last) state_d = MD_FIX;
      end
      MD_FIX: begin
        stall_raw = 1'b1;
        if (div_q) begin
          lo_d = neg_q  ? -core_sh  : core_sh;
          hi_d = rneg_q ? -core_acc : core_acc;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = MD_DONE;
      end
      MD_DONE: begin
        done_raw  = 1'b1;
        read_ok   = 1'b1;
        stall_raw = mt_op;
        state_d   = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Controller state and HI/LO registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
    end
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (core_load),
    .run    (core_run),
    .is_div (state_q == MD_DIV),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .acc    (core_acc),
    .shreg  (core_sh),
    .last   (core_last)
  );

  assign md_stall    = rst_n && stall_raw;
  assign md_done     = rst_n && done_raw;
  assign md_result   = (mf_op && read_ok) ? ((funct == F_MFHI) ? hi_q : lo_q) : '0;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_md_ctrl.sv
// Bench for alu_md_ctrl: cycle-level HI/LO model, per-cycle compare, directed pins, random traffic.
module tb_alu_md_ctrl;
  import mips_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    funct = '0;
  logic [1:0]    alu_ctrl = '0;
  logic          instr_valid = 1'b0;
  logic [W-1:0]  rs_val = '0;
  logic [W-1:0]  rt_val = '0;
  logic [3:0]    alu_op;
  logic          illegal;
  logic          md_stall;
  logic [W-1:0]  md_result;
  logic          md_done;
  logic          div_by_zero;
  md_state_e     dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  alu_md_ctrl #(.WIDTH(W), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .funct(funct), .alu_ctrl(alu_ctrl),
    .instr_valid(instr_valid), .rs_val(rs_val), .rt_val(rt_val),
    .alu_op(alu_op), .illegal(illegal), .md_stall(md_stall),
    .md_result(md_result), .md_done(md_done), .div_by_zero(div_by_zero),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] exp_decode(input logic [1:0] c, input logic [5:0] f);
    case (c)
      2'b00: return 5'h02;
      2'b01: return 5'h06;
      2'b11: return 5'h07;
      default: begin
        case (f)
          6'h20, 6'h21: return 5'h02;
          6'h22, 6'h23: return 5'h06;
          6'h24: return 5'h00;
          6'h25: return 5'h01;
          6'h26: return 5'h03;
          6'h27: return 5'h04;
          6'h2A: return 5'h07;
          6'h2B: return 5'h08;
          6'h00: return 5'h09;
          6'h02: return 5'h0A;
          6'h03: return 5'h0B;
          6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: return 5'h02;
          default: return 5'h12;
        endcase
      end
    endcase
  endfunction

  // Returns {HI, LO} for a mult/div funct using plain arithmetic
  function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = a;
    sb = b;
    case (f)
      6'h18: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      6'h19: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      6'h1A: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_dbz = 1'b0, m_busy = 1'b0;
  int          cyc = 0, done_cyc = 0;

  // Model advances on the same edge the DUT samples
  always @(posedge clk) begin
    logic [63:0] r;
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_dbz <= 1'b0; m_busy <= 1'b0;
    end else if (m_busy) begin
      if (cyc == done_cyc - 1) begin
        m_hi <= p_hi; m_lo <= p_lo;
      end
      if (cyc == done_cyc) m_busy <= 1'b0;
    end else if (instr_valid && alu_ctrl == 2'b10) begin
      if (funct inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
        r = md_model(funct, rs_val, rt_val);
        m_busy <= 1'b1;
        if ((funct inside {6'h1A, 6'h1B}) && rt_val == 0) begin
          done_cyc <= cyc + 1;
          m_hi <= r[63:32]; m_lo <= r[31:0];
          m_dbz <= 1'b1;
        end else begin
          done_cyc <= cyc + W + 2;
          p_hi <= r[63:32]; p_lo <= r[31:0];
          m_dbz <= 1'b0;
        end
      end else if (funct == 6'h11) begin
        m_hi <= rs_val; m_dbz <= 1'b0;
      end else if (funct == 6'h13) begin
        m_lo <= rs_val; m_dbz <= 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic is_r, is_md, is_mf, is_mt, in_done, before_done, e_stall;
    logic [31:0] e_res;
    logic [4:0] dec;
    if (rst_n) begin
      is_r        = (alu_ctrl == 2'b10);
      is_md       = instr_valid && is_r && (funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
      is_mf       = instr_valid && is_r && (funct inside {6'h10, 6'h12});
      is_mt       = instr_valid && is_r && (funct inside {6'h11, 6'h13});
      in_done     = m_busy && (cyc == done_cyc);
      before_done = m_busy && (cyc < done_cyc);
      e_stall     = before_done || (!m_busy && is_md) || (in_done && is_mt);
      e_res       = (is_mf && !e_stall) ? ((funct == 6'h10) ? m_hi : m_lo) : 32'd0;
      dec         = exp_decode(alu_ctrl, funct);
      check("alu_op", 32'(alu_op), 32'(dec[3:0]));
      check("illegal", 32'(illegal), 32'(dec[4]));
      check("md_stall", 32'(md_stall), 32'(e_stall));
      check("md_done", 32'(md_done), 32'(in_done));
      check("md_result", md_result, e_res);
      check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end
  end

  // ---------------- driver tasks ----------------
  // Present one instruction, hold it while stalled (optionally switching funct at cycle sw_at),
  // then drop it after the first unstalled cycle.
  task automatic drive(input logic [1:0] c, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int sw_at, input logic [5:0] sw_f,
                       output int n_stall, output int done_at, output logic [31:0] res,
                       output logic [3:0] op, output logic ill);
    bit ok;
    @(posedge clk); #1;
    instr_valid = 1'b1; alu_ctrl = c; funct = f; rs_val = a; rt_val = b;
    n_stall = 0; done_at = -1; ok = 1'b0; res = '0; op = '0; ill = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == sw_at) funct = sw_f;
      end
      @(negedge clk);
      if (md_done) done_at = k;
      if (!md_stall) begin
        res = md_result; op = alu_op; ill = illegal; ok = 1'b1;
        break;
      end
      n_stall++;
    end
    if (!ok) check("stall_release_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    alu_ctrl = 2'($urandom); funct = 6'($urandom);
    rs_val = $urandom; rt_val = $urandom;
  endtask

  task automatic verify_hilo(input logic [31:0] eh, input logic [31:0] el);
    int ns, da; logic [31:0] r; logic [3:0] o; logic il;
    exp_q.push_back(eh);
    exp_q.push_back(el);
    drive(2'b10, 6'h10, 32'd0, 32'd0, -1, 6'h0, ns, da, r, o, il);
    check("pin_mfhi", r, exp_q.pop_front());
    drive(2'b10, 6'h12, 32'd0, 32'd0, -1, 6'h0, ns, da, r, o, il);
    check("pin_mflo", r, exp_q.pop_front());
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0; instr_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int ns, da; logic [31:0] r; logic [3:0] o; logic il;
    logic [5:0] md_list[4];
    md_list = '{6'h18, 6'h19, 6'h1A, 6'h1B};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_stall", 32'(md_stall), 32'd0);
    check("reset_done", 32'(md_done), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    verify_hilo(32'd0, 32'd0);

    // Decode pins
    drive(2'b10, 6'h22, 32'd0, 32'd0, -1, 6'h0, ns, da, r, o, il);
    check("dec_sub_op", 32'(o), 32'h6);
    check("dec_sub_ill", 32'(il), 32'd0);
    drive(2'b10, 6'h3F, 32'd0, 32'd0, -1, 6'h0, ns, da, r, o, il);
    check("dec_3f_op", 32'(o), 32'h2);
    check("dec_3f_ill", 32'(il), 32'd1);
    drive(2'b01, 6'h20, 32'd0, 32'd0, -1, 6'h0, ns, da, r, o, il);
    check("dec_branch_op", 32'(o), 32'h6);

    // Signed multiply with latency and stall-cycle pins
    drive(2'b10, 6'h18, 32'hFFFF_FFFD, 32'd5, -1, 6'h0, ns, da, r, o, il);
    check("mult_done_cycle", 32'(da), 32'd34);
    check("mult_stall_cycles", 32'(ns), 32'd34);
    verify_hilo(32'hFFFF_FFFF, 32'hFFFF_FFF1);

    drive(2'b10, 6'h1B, 32'd100, 32'd7, -1, 6'h0, ns, da, r, o, il);
    verify_hilo(32'd2, 32'd14);
    drive(2'b10, 6'h1A, 32'hFFFF_FFF9, 32'd2, -1, 6'h0, ns, da, r, o, il);
    verify_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Divide by zero: immediate DONE, sticky flag, cleared by MTLO
    drive(2'b10, 6'h1A, 32'h0000_002A, 32'd0, -1, 6'h0, ns, da, r, o, il);
    check("dbz_done_cycle", 32'(da), 32'd1);
    check("dbz_stall_cycles", 32'(ns), 32'd1);
    @(negedge clk);
    check("dbz_flag_set", 32'(div_by_zero), 32'd1);
    verify_hilo(32'h0000_002A, 32'hFFFF_FFFF);
    check("dbz_flag_sticky", 32'(div_by_zero), 32'd1);
    drive(2'b10, 6'h13, 32'd5, 32'd0, -1, 6'h0, ns, da, r, o, il);
    @(negedge clk);
    check("dbz_flag_cleared", 32'(div_by_zero), 32'd0);

    // MFLO arrives mid-operation and receives the forwarded result in DONE
    drive(2'b10, 6'h19, 32'd3, 32'd4, 5, 6'h12, ns, da, r, o, il);
    check("mflo_forward", r, 32'h0000_000C);
    check("mflo_forward_done", 32'(da), 32'd34);
    drive(2'b10, 6'h10, 32'd0, 32'd0, -1, 6'h0, ns, da, r, o, il);
    check("mfhi_after", r, 32'd0);
    check("mfhi_no_stall", 32'(ns), 32'd0);

    // Most-negative / -1 wraps
    drive(2'b10, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, -1, 6'h0, ns, da, r, o, il);
    verify_hilo(32'd0, 32'h8000_0000);

    // Reset in the middle of a DIVU
    @(posedge clk); #1;
    instr_valid = 1'b1; alu_ctrl = 2'b10; funct = 6'h1B; rs_val = 32'd1000; rt_val = 32'd3;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0; instr_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_stall", 32'(md_stall), 32'd0);
    verify_hilo(32'd0, 32'd0);
    drive(2'b10, 6'h19, 32'd2, 32'd2, -1, 6'h0, ns, da, r, o, il);
    verify_hilo(32'd0, 32'd4);

    // Random traffic checked by the compare process
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      int sel;
      a = rand_opnd();
      b = rand_opnd();
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        drive(2'b10, md_list[$urandom_range(0, 3)], a, b, -1, 6'h0, ns, da, r, o, il);
        check("rand_md_done_seen", 32'(da >= 0), 32'd1);
      end else if (sel <= 6) begin
        drive(2'b10, ($urandom_range(0, 1) != 0) ? 6'h11 : 6'h13, a, b, -1, 6'h0, ns, da, r, o, il);
      end else if (sel == 7) begin
        drive(2'b10, ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12, a, b, -1, 6'h0, ns, da, r, o, il);
      end else if (sel == 8) begin
        drive(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), a, b, -1, 6'h0, ns, da, r, o, il);
      end else begin
        pulse_reset($urandom_range(1, 2));
      end
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_md_ctrl.md
Name: alu_md_ctrl

Overview:
- Successor ALU control unit for the MIPS datapath, sitting in EX between the main decoder and the ALU.
- Widens the ALU operation code and fully decodes R-type funct fields.
- Adds a sequential multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO registers and a pipeline stall handshake.
- Owns HI/LO and serves MFHI/MFLO/MTHI/MTLO.

Parameters:
- WIDTH, 32, datapath width; HI and LO are each WIDTH bits; must be even and ≥ 4.
- OP_W, 4, width of alu_op.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- funct  in  6  instruction funct field.
- alu_ctrl  in  2  class from main decoder: 00 load/store, 01 branch, 10 R-type, 11 set-less-than immediate.
- instr_valid  in  1  EX stage holds a valid instruction this cycle.
- rs_val  in  WIDTH  operand A.
- rt_val  in  WIDTH  operand B.
- alu_op  out  OP_W  combinational ALU operation.
- illegal  out  1  combinational: R-type with unsupported funct.
- md_stall  out  1  combinational: hold IF/ID/EX this cycle.
- md_result  out  WIDTH  HI or LO for MFHI/MFLO, otherwise 0.
- md_done  out  1  one-cycle pulse when HI/LO are updated by mult/div.
- div_by_zero  out  1  sticky flag; cleared by the next accepted MULT/DIV/MTHI/MTLO.

Behaviour:
- ALU decode (combinational):
  - alu_op encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SUB 0110, SLT 0111, SLTU 1000, SLL 1001, SRL 1010, SRA 1011.
  - alu_ctrl 00 → ADD; 01 → SUB; 11 → SLT.
  - alu_ctrl 10 → decode by funct: 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU, 00 SLL, 02 SRL, 03 SRA.
  - Mult/div and HI/LO funct codes (10,11,12,13,18,19,1A,1B) → ADD with illegal=0.
  - Any other funct → ADD with illegal=1.
- md operation issues only when instr_valid=1 and alu_ctrl=10.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE, MULT/MULTU (18/19) → MUL: latch |rs|, |rt| (signed) or raw (unsigned); record result sign; cnt=0.
  - IDLE, DIV/DIVU (1A/1B) with rt≠0 → DIV, latching the same way.
  - IDLE, DIV/DIVU with rt=0 → DONE: LO=all ones, HI=rs_val, div_by_zero=1.
  - MUL: radix-2 shift-add, one bit per cycle; after WIDTH iterations → FIX.
  - DIV: restoring, one quotient bit per cycle; after WIDTH iterations → FIX.
  - FIX: apply two's-complement negate to product, or to quotient/remainder (remainder takes dividend sign); write HI/LO → DONE.
  - DONE: md_done=1 → IDLE.
- Latency: operation accepted at cycle 0; HI/LO valid and md_done high at cycle WIDTH+2.
- md_stall:
  - High in MUL, DIV and FIX, so the issuing instruction and followers hold.
  - Low in DONE.
  - Also high in IDLE when a new md op is presented in the same cycle it is accepted. The issuing instruction therefore sits in EX until DONE, and instr_valid stays high throughout; the FSM ignores it outside IDLE.
- MFHI/MFLO (10/12):
  - In IDLE: md_result = HI/LO combinationally, no stall.
  - Otherwise stall until DONE, where the new value is forwarded.
- MTHI/MTLO (11/13): in IDLE, write rs_val on the clock edge with no stall; otherwise stall.
- Signed DIV of most-negative by -1 wraps: LO=most-negative, HI=0.
- Reset (any state, including mid-operation): FSM to IDLE; HI=LO=0; cnt=0; md_done=0; div_by_zero=0; md_stall=0.
- Internal counter width: $clog2(WIDTH)+1.

Decomposition:
- Package mips_pkg:
  - alu_op_e enum (OP_W bits) with the encodings above.
  - funct localparams.
  - alu_ctrl class localparams.
  - md_state_e enum.
- One sub-module: md_iter_core (MUL/DIV datapath: accumulator, shift register, counter), controlled by the FSM in alu_md_ctrl. Decode and HI/LO stay in the top.

Test Plan:
- alu_ctrl=10, funct 22 → alu_op=0110, illegal=0; funct 3F → alu_op=0010, illegal=1; alu_ctrl=01 → 0110.
- MULT rs=FFFFFFFD, rt=00000005 → md_done at cycle 34; HI=FFFFFFFF, LO=FFFFFFF1; md_stall high cycles 0–33.
- DIVU rs=100, rt=7 → LO=14, HI=2. DIV rs=-7, rt=2 → LO=FFFFFFFD, HI=FFFFFFFF.
- DIV rs=0000002A, rt=0 → DONE after 1 cycle; LO=FFFFFFFF, HI=0000002A, div_by_zero=1; next MTLO clears it.
- MULTU 3×4, then MFLO issued at cycle 5 → stalled until DONE; md_result=0000000C; MFHI afterwards returns 0 with no stall.
- Reset asserted at cycle 10 of a DIVU → next cycle IDLE, HI=LO=0, md_stall=0; a following MULTU 2×2 yields LO=4.
